// File: rtl/fifo_ctrl_d0_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_d0_pkg
//   Shared definitions for the main-queue pointer/flag controller:
//   - fifo_state_t : controller FSM encoding (3-bit)
//   - fifo_depth() : queue depth derived from the address width
// -----------------------------------------------------------------------------
package fifo_ctrl_d0_pkg;

   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_EMPTY  = 3'd1,
      ST_ACTIVE = 3'd2,
      ST_FULL   = 3'd3,
      ST_ERROR  = 3'd4
   } fifo_state_t;

   function automatic int unsigned fifo_depth(input int unsigned aw);
      return 32'd1 << aw;
   endfunction

endpackage

// File: rtl/fifo_ptr_d0.sv
// -----------------------------------------------------------------------------
// fifo_ptr_d0
//   WIDTH-bit queue address pointer. It advances by one on each clock where
//   i_inc is high and wraps naturally at 2**WIDTH.
//   Ports:
//     clk    : clock, posedge
//     reset  : asynchronous, active-high; clears the pointer to 0
//     i_inc  : advance request
//     o_ptr  : current pointer value
// -----------------------------------------------------------------------------
module fifo_ptr_d0 #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_ptr
);

   logic [WIDTH-1:0] r_ptr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (i_inc) begin
         r_ptr <= r_ptr + 1'b1;
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl_d0.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_d0
//   Pointer and flag controller for the main queue. It accepts push/pop
//   requests, drives the RAM write/read enables and addresses, and tracks
//   occupancy. A push while full or a pop while empty traps the controller in
//   a sticky ERROR state until err_clear is pulsed.
//   Optional feature: define FIFO_CTRL_PEAK_EN to make peak_count a register
//   that holds the highest occupancy seen since reset; otherwise it is tied
//   to 0.
//   Ports:
//     clk, reset              : clock (posedge), async active-high reset
//     push, pop               : producer / consumer requests
//     err_clear               : leaves ERROR (ignored in all other states)
//     umbral_alto/umbral_bajo : almost-full / almost-empty thresholds (live)
//     write, read             : RAM write / read enables (same-cycle accept)
//     wr_ptr, rd_ptr          : RAM write / read addresses
//     fifo_count              : occupancy, 0..DEPTH
//     full, empty             : occupancy flags
//     almost_full/almost_empty: threshold flags
//     overflow_err/underflow_err : sticky error bits
//     peak_count              : maximum occupancy seen (optional feature)
// -----------------------------------------------------------------------------
module fifo_ctrl_d0
   import fifo_ctrl_d0_pkg::*;
#(
   parameter int unsigned DATA_SIZE       = 10,
   parameter int unsigned MAIN_QUEUE_SIZE = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       err_clear,
   input  logic [MAIN_QUEUE_SIZE:0]   umbral_alto,
   input  logic [MAIN_QUEUE_SIZE:0]   umbral_bajo,
   output logic                       write,
   output logic                       read,
   output logic [MAIN_QUEUE_SIZE-1:0] wr_ptr,
   output logic [MAIN_QUEUE_SIZE-1:0] rd_ptr,
   output logic [MAIN_QUEUE_SIZE:0]   fifo_count,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic                       overflow_err,
   output logic                       underflow_err,
   output logic [MAIN_QUEUE_SIZE:0]   peak_count
);

   localparam logic [MAIN_QUEUE_SIZE:0] DEPTH_C =
      (MAIN_QUEUE_SIZE+1)'(fifo_depth(MAIN_QUEUE_SIZE));

   // DATA_SIZE only has to match the RAM word width; reject a degenerate setup.
   if (DATA_SIZE == 0 || MAIN_QUEUE_SIZE == 0) begin : g_bad_params
      $error("fifo_ctrl_d0: DATA_SIZE and MAIN_QUEUE_SIZE must be nonzero");
   end

   fifo_state_t              r_state;
   fifo_state_t              w_state_nxt;
   logic [MAIN_QUEUE_SIZE:0] r_count;
   logic [MAIN_QUEUE_SIZE:0] w_count_nxt;
   logic                     r_ovf;
   logic                     r_udf;
   logic                     w_push_ok;
   logic                     w_pop_ok;
   logic                     w_ovf_set;
   logic                     w_udf_set;
   logic                     w_err_clear;

   function automatic fifo_state_t f_level_state(input logic [MAIN_QUEUE_SIZE:0] cnt);
      if (cnt == '0) begin
         return ST_EMPTY;
      end else if (cnt == DEPTH_C) begin
         return ST_FULL;
      end else begin
         return ST_ACTIVE;
      end
   endfunction

   // Acceptance, error detection and next state. The level states are re-derived
   // from the post-update count, so a push+pop in FULL lands back in FULL.
   always_comb begin
      w_push_ok   = 1'b0;
      w_pop_ok    = 1'b0;
      w_ovf_set   = 1'b0;
      w_udf_set   = 1'b0;
      w_err_clear = 1'b0;
      w_state_nxt = r_state;
      w_count_nxt = r_count;

      case (r_state)
         ST_INIT: begin
            w_state_nxt = ST_EMPTY;
         end
         ST_EMPTY: begin
            w_push_ok = push;
            w_udf_set = pop;
         end
         ST_ACTIVE: begin
            w_push_ok = push;
            w_pop_ok  = pop;
         end
         ST_FULL: begin
            w_push_ok = push & pop;
            w_pop_ok  = pop;
            w_ovf_set = push & ~pop;
         end
         ST_ERROR: begin
            if (err_clear) begin
               w_err_clear = 1'b1;
               w_state_nxt = f_level_state(r_count);
            end
         end
         default: begin
            w_state_nxt = ST_INIT;
         end
      endcase

      if (w_push_ok && !w_pop_ok) begin
         w_count_nxt = r_count + 1'b1;
      end else if (w_pop_ok && !w_push_ok) begin
         w_count_nxt = r_count - 1'b1;
      end

      if (r_state == ST_EMPTY || r_state == ST_ACTIVE || r_state == ST_FULL) begin
         w_state_nxt = (w_ovf_set || w_udf_set) ? ST_ERROR : f_level_state(w_count_nxt);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_INIT;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         if (w_err_clear) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
         end else begin
            if (w_ovf_set) r_ovf <= 1'b1;
            if (w_udf_set) r_udf <= 1'b1;
         end
      end
   end

   fifo_ptr_d0 #(.WIDTH(MAIN_QUEUE_SIZE)) u_wr_ptr (
      .clk   (clk),
      .reset (reset),
      .i_inc (w_push_ok),
      .o_ptr (wr_ptr)
   );

   fifo_ptr_d0 #(.WIDTH(MAIN_QUEUE_SIZE)) u_rd_ptr (
      .clk   (clk),
      .reset (reset),
      .i_inc (w_pop_ok),
      .o_ptr (rd_ptr)
   );

`ifdef FIFO_CTRL_PEAK_EN
   logic [MAIN_QUEUE_SIZE:0] r_peak;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_peak <= '0;
      end else if (w_count_nxt > r_peak) begin
         r_peak <= w_count_nxt;
      end
   end

   assign peak_count = r_peak;
`else
   assign peak_count = '0;
`endif

   assign write         = w_push_ok;
   assign read          = w_pop_ok;
   assign fifo_count    = r_count;
   assign full          = (r_count == DEPTH_C);
   assign empty         = (r_count == '0);
   assign almost_full   = (r_count >= umbral_alto);
   assign almost_empty  = (r_count <= umbral_bajo);
   assign overflow_err  = r_ovf;
   assign underflow_err = r_udf;

endmodule

// File: tb/tb_fifo_ctrl_d0.sv
// -----------------------------------------------------------------------------
// tb_fifo_ctrl_d0
//   Self-checking bench for fifo_ctrl_d0 with MAIN_QUEUE_SIZE=3 (DEPTH=8).
//   Directed scenarios are followed by randomized push/pop/err_clear traffic.
//   Expected values come from an occupancy/total-transfer model of the queue.
// -----------------------------------------------------------------------------
module tb_fifo_ctrl_d0;

   localparam int unsigned AW    = 3;
   localparam int          DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset;
   logic          push;
   logic          pop;
   logic          err_clear;
   logic [AW:0]   umbral_alto;
   logic [AW:0]   umbral_bajo;
   logic          write;
   logic          read;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   fifo_count;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic          overflow_err;
   logic          underflow_err;
   logic [AW:0]   peak_count;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: occupancy plus total accepted pushes/pops since reset.
   bit m_init;
   bit m_err;
   bit m_ovf;
   bit m_udf;
   int m_count;
   int m_pushes;
   int m_pops;
   int m_peak;

   fifo_ctrl_d0 #(
      .DATA_SIZE       (10),
      .MAIN_QUEUE_SIZE (AW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .push          (push),
      .pop           (pop),
      .err_clear     (err_clear),
      .umbral_alto   (umbral_alto),
      .umbral_bajo   (umbral_bajo),
      .write         (write),
      .read          (read),
      .wr_ptr        (wr_ptr),
      .rd_ptr        (rd_ptr),
      .fifo_count    (fifo_count),
      .full          (full),
      .empty         (empty),
      .almost_full   (almost_full),
      .almost_empty  (almost_empty),
      .overflow_err  (overflow_err),
      .underflow_err (underflow_err),
      .peak_count    (peak_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_push_ok();
      return !m_init && !m_err && push && (m_count < DEPTH || pop);
   endfunction

   function automatic bit m_pop_ok();
      return !m_init && !m_err && pop && (m_count > 0);
   endfunction

   task automatic model_reset();
      m_init   = 1'b1;
      m_err    = 1'b0;
      m_ovf    = 1'b0;
      m_udf    = 1'b0;
      m_count  = 0;
      m_pushes = 0;
      m_pops   = 0;
      m_peak   = 0;
   endtask

   task automatic model_update();
      bit pk;
      bit pp;
      pk = m_push_ok();
      pp = m_pop_ok();
      if (m_init) begin
         m_init = 1'b0;
      end else if (m_err) begin
         if (err_clear) begin
            m_err = 1'b0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
         end
      end else begin
         if (push && !pop && m_count == DEPTH) begin
            m_ovf = 1'b1;
            m_err = 1'b1;
         end
         if (pop && m_count == 0) begin
            m_udf = 1'b1;
            m_err = 1'b1;
         end
         m_count  = m_count + int'(pk) - int'(pp);
         m_pushes = m_pushes + int'(pk);
         m_pops   = m_pops + int'(pp);
         if (m_count > m_peak) m_peak = m_count;
      end
   endtask

   task automatic check_outputs();
      int exp_peak;
`ifdef FIFO_CTRL_PEAK_EN
      exp_peak = m_peak;
`else
      exp_peak = 0;
`endif
      check_eq("write",         32'(write),         32'(m_push_ok()));
      check_eq("read",          32'(read),          32'(m_pop_ok()));
      check_eq("wr_ptr",        32'(wr_ptr),        32'(m_pushes % DEPTH));
      check_eq("rd_ptr",        32'(rd_ptr),        32'(m_pops % DEPTH));
      check_eq("fifo_count",    32'(fifo_count),    32'(m_count));
      check_eq("full",          32'(full),          32'(m_count == DEPTH));
      check_eq("empty",         32'(empty),         32'(m_count == 0));
      check_eq("almost_full",   32'(almost_full),   32'(m_count >= int'(umbral_alto)));
      check_eq("almost_empty",  32'(almost_empty),  32'(m_count <= int'(umbral_bajo)));
      check_eq("overflow_err",  32'(overflow_err),  32'(m_ovf));
      check_eq("underflow_err", 32'(underflow_err), 32'(m_udf));
      check_eq("peak_count",    32'(peak_count),    32'(exp_peak));
   endtask

   // One clock cycle: drive on the falling edge, check, then let the rising edge land.
   task automatic step(input bit p, input bit q, input bit c);
      @(negedge clk);
      push      = p;
      pop       = q;
      err_clear = c;
      #1;
      check_outputs();
      model_update();
      @(posedge clk);
   endtask

   // Asynchronous reset mid-cycle; inputs are left as they are.
   task automatic do_reset();
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk);
      #2;
      reset = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      push        = 1'b0;
      pop         = 1'b0;
      err_clear   = 1'b0;
      umbral_alto = (AW+1)'(6);
      umbral_bajo = (AW+1)'(2);
      model_reset();
      #1;
      check_outputs();
      @(posedge clk);
      #2;
      reset = 1'b0;

      // INIT cycle ignores push, then fill to full with wrap of wr_ptr.
      step(1, 0, 0);
      repeat (DEPTH) step(1, 0, 0);
      // Push+pop while full, then overflow.
      step(1, 1, 0);
      step(1, 0, 0);
      repeat (2) step(0, 1, 0);
      step(0, 0, 1);
      step(0, 1, 0);
      step(0, 0, 0);

      // Underflow with simultaneous push.
      do_reset();
      step(0, 0, 0);
      step(1, 1, 0);
      step(1, 0, 0);
      step(0, 0, 1);
      step(0, 0, 0);

      // Peak tracking, then reset mid-burst at count 5.
      do_reset();
      step(0, 0, 0);
      repeat (5) step(1, 0, 0);
      repeat (3) step(0, 1, 0);
      repeat (3) step(1, 0, 0);
      push = 1'b1;
      do_reset();
      step(1, 0, 0);
      step(0, 0, 0);

      // Randomized traffic with varying bias and live thresholds.
      for (int ph = 0; ph < 24; ph++) begin
         int unsigned pr_push;
         int unsigned pr_pop;
         pr_push     = $urandom_range(10, 95);
         pr_pop      = $urandom_range(5, 90);
         umbral_alto = (AW+1)'($urandom_range(0, DEPTH + 3));
         umbral_bajo = (AW+1)'($urandom_range(0, DEPTH + 1));
         if (ph % 6 == 5) do_reset();
         for (int i = 0; i < 120; i++) begin
            step($urandom_range(0, 99) < pr_push,
                 $urandom_range(0, 99) < pr_pop,
                 $urandom_range(0, 99) < 8);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
